// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC coefficient buffering blocks.
//
// Contents:
//   MFCC_COEF_W    - default coefficient width in bits (32)
//   MFCC_FRAME_LEN - default coefficients per MFCC frame (20)
//   wr_state_e     - write-side state of the frame FIFO (W_FILL, W_DISCARD)
//   ptr_w()        - bit width needed to index n entries, never below 1
package mfcc_pkg;

    localparam int MFCC_COEF_W    = 32;
    localparam int MFCC_FRAME_LEN = 20;

    typedef enum logic [0:0] {
        W_FILL    = 1'b0,
        W_DISCARD = 1'b1
    } wr_state_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mfcc_frame_ptr.sv
// Slot/word pointer pair for a frame-granular buffer.
//
// The word pointer counts 0..FRAME_LEN-1 inside the current slot; finishing
// the last word wraps it to 0 and moves the slot pointer on (wrapping
// NUM_FRAMES-1 -> 0). A restart drops the current frame by returning the word
// pointer to 0 while keeping the slot.
//
// Ports:
//   clk        in   clock, posedge
//   rstn       in   asynchronous active-low reset, pointers to 0
//   adv        in   one word consumed/produced this cycle
//   restart    in   abandon the frame in progress (takes priority over adv)
//   slot       out  current slot index
//   word       out  current word index within the slot
//   last_word  out  word == FRAME_LEN-1
//   frame_done out  strobe: the last word of the slot advances this cycle
module mfcc_frame_ptr
    import mfcc_pkg::*;
#(
    parameter  int FRAME_LEN  = MFCC_FRAME_LEN,
    parameter  int NUM_FRAMES = 4,
    localparam int SLOT_W     = ptr_w(NUM_FRAMES),
    localparam int WORD_W     = ptr_w(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              adv,
    input  logic              restart,
    output logic [SLOT_W-1:0] slot,
    output logic [WORD_W-1:0] word,
    output logic              last_word,
    output logic              frame_done
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [WORD_W-1:0] word_q, word_d;

    assign last_word  = (word_q == WORD_W'(FRAME_LEN - 1));
    assign frame_done = adv & ~restart & last_word;
    assign slot       = slot_q;
    assign word       = word_q;

    always_comb begin
        slot_d = slot_q;
        word_d = word_q;
        if (restart) begin
            word_d = '0;
        end else if (adv) begin
            if (last_word) begin
                word_d = '0;
                slot_d = (slot_q == SLOT_W'(NUM_FRAMES - 1)) ? '0 : slot_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q <= '0;
            word_q <= '0;
        end else begin
            slot_q <= slot_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mfcc_frame_fifo.sv
// Frame-granular FIFO between the MFCC coefficient engine and the
// classifier/DMA. Holds up to NUM_FRAMES complete frames of FRAME_LEN words in
// a pointer-addressed memory. A frame is visible to the reader only after its
// final word is written (commit); the reader sees the head word
// combinationally (first-word fall-through).
//
// Build option:
//   MFCC_FRAME_FIFO_LEN_CHECK_EN - when defined, wr_last is checked against
//   the word count: short frames are dropped, long frames are dropped up to
//   their wr_last (W_DISCARD), and each drop pulses wr_err. When undefined,
//   wr_last is ignored, frames are delimited purely by count, wr_err is 0.
//
// Ports:
//   clk        in   clock, posedge
//   rstn       in   asynchronous active-low reset
//   wr_valid   in   write word offered
//   wr_data    in   coefficient [DATA_W]
//   wr_last    in   final coefficient of a frame
//   wr_ready   out  write accepted when wr_valid & wr_ready
//   rd_valid   out  a committed word is presented
//   rd_data    out  head coefficient [DATA_W]
//   rd_first   out  rd_data is word 0 of its frame
//   rd_last    out  rd_data is word FRAME_LEN-1 of its frame
//   rd_ready   in   read accepted when rd_valid & rd_ready
//   frame_cnt  out  committed frames not yet fully read
//   wr_err     out  one-cycle pulse when a malformed frame is dropped
module mfcc_frame_fifo
    import mfcc_pkg::*;
#(
    parameter int DATA_W     = MFCC_COEF_W,
    parameter int FRAME_LEN  = MFCC_FRAME_LEN,
    parameter int NUM_FRAMES = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wr_valid,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            wr_last,
    output logic                            wr_ready,
    output logic                            rd_valid,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_first,
    output logic                            rd_last,
    input  logic                            rd_ready,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frame_cnt,
    output logic                            wr_err
);

    localparam int DEPTH  = NUM_FRAMES * FRAME_LEN;
    localparam int ADDR_W = ptr_w(DEPTH);
    localparam int CNT_W  = $clog2(NUM_FRAMES + 1);
    localparam int SLOT_W = ptr_w(NUM_FRAMES);
    localparam int WORD_W = ptr_w(FRAME_LEN);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic              wr_acc, rd_acc, mem_we, fill_room;
    logic              wr_adv, wr_restart, wr_commit;
    logic              rd_done, rd_at_last, wr_at_last;
    logic [SLOT_W-1:0] wr_slot, rd_slot;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign fill_room = (frame_cnt_q < CNT_W'(NUM_FRAMES));
    assign wr_acc    = wr_valid & wr_ready;
    assign rd_valid  = (frame_cnt_q != '0);
    assign rd_acc    = rd_valid & rd_ready;
    assign frame_cnt = frame_cnt_q;

    mfcc_frame_ptr #(
        .FRAME_LEN (FRAME_LEN),
        .NUM_FRAMES(NUM_FRAMES)
    ) u_wr_ptr (
        .clk       (clk),
        .rstn      (rstn),
        .adv       (wr_adv),
        .restart   (wr_restart),
        .slot      (wr_slot),
        .word      (wr_word),
        .last_word (wr_at_last),
        .frame_done(wr_commit)
    );

    mfcc_frame_ptr #(
        .FRAME_LEN (FRAME_LEN),
        .NUM_FRAMES(NUM_FRAMES)
    ) u_rd_ptr (
        .clk       (clk),
        .rstn      (rstn),
        .adv       (rd_acc),
        .restart   (1'b0),
        .slot      (rd_slot),
        .word      (rd_word),
        .last_word (rd_at_last),
        .frame_done(rd_done)
    );

`ifdef MFCC_FRAME_FIFO_LEN_CHECK_EN
    wr_state_e st_q, st_d;
    logic      wr_err_q, wr_err_d;

    // Discarding never stalls the writer, so a long frame cannot deadlock a
    // full FIFO; only W_FILL is held off by the frame count.
    assign wr_ready = (st_q == W_DISCARD) | fill_room;
    assign mem_we   = wr_acc & (st_q == W_FILL);
    assign wr_err   = wr_err_q;

    always_comb begin
        st_d       = st_q;
        wr_err_d   = 1'b0;
        wr_adv     = 1'b0;
        wr_restart = 1'b0;
        case (st_q)
            W_FILL: begin
                if (wr_acc) begin
                    wr_adv = 1'b1;
                    if (wr_last && !wr_at_last) begin
                        // Short frame: rewind the slot, nothing committed.
                        wr_restart = 1'b1;
                        wr_err_d   = 1'b1;
                    end else if (!wr_last && wr_at_last) begin
                        // Long frame: slot is full but unterminated; drop the
                        // rest up to wr_last and flag it then.
                        wr_restart = 1'b1;
                        st_d       = W_DISCARD;
                    end
                end
            end
            W_DISCARD: begin
                if (wr_acc && wr_last) begin
                    st_d     = W_FILL;
                    wr_err_d = 1'b1;
                end
            end
            default: st_d = W_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q     <= W_FILL;
            wr_err_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            wr_err_q <= wr_err_d;
        end
    end
`else
    logic unused_wr_last;

    assign unused_wr_last = wr_last;
    assign wr_ready       = fill_room;
    assign mem_we         = wr_acc;
    assign wr_adv         = wr_acc;
    assign wr_restart     = 1'b0;
    assign wr_err         = 1'b0;
`endif

    // A commit and a final-word read in the same cycle cancel out.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        case ({wr_commit, rd_done})
            2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
            2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign wr_addr = ADDR_W'(wr_slot) * ADDR_W'(FRAME_LEN) + ADDR_W'(wr_word);
    assign rd_addr = ADDR_W'(rd_slot) * ADDR_W'(FRAME_LEN) + ADDR_W'(rd_word);

    // Storage is data only: no reset, contents after reset are don't-care
    // because frame_cnt gates visibility.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_addr];
    assign rd_first = rd_valid & (rd_word == '0);
    assign rd_last  = rd_valid & rd_at_last;

endmodule

// File: tb/tb_mfcc_frame_fifo.sv
module tb_mfcc_frame_fifo;

    localparam int DW = 32;
    localparam int FL = 20;
    localparam int NF = 4;
    localparam int CW = $clog2(NF + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_first;
    logic          rd_last;
    logic          rd_ready;
    logic [CW-1:0] frame_cnt;
    logic          wr_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mfcc_frame_fifo #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .NUM_FRAMES(NF)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_first (rd_first),
        .rd_last  (rd_last),
        .rd_ready (rd_ready),
        .frame_cnt(frame_cnt),
        .wr_err   (wr_err)
    );

    // Reference model: committed words in read order, the frame being
    // assembled, the discard flag and the error expected after the last edge.
    logic [DW-1:0] cq[$];
    logic [DW-1:0] pq[$];
    bit            discard = 1'b0;
    bit            exp_err = 1'b0;

    function automatic int m_cnt();
        return (cq.size() + FL - 1) / FL;
    endfunction

    function automatic bit m_rd_valid();
        return cq.size() != 0;
    endfunction

    function automatic bit m_wr_ready();
        return discard || (m_cnt() < NF);
    endfunction

    function automatic bit m_first();
        return (cq.size() != 0) && (cq.size() % FL == 0);
    endfunction

    function automatic bit m_last();
        return cq.size() % FL == 1;
    endfunction

    task automatic model_clear();
        cq.delete();
        pq.delete();
        discard = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic model_commit();
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
    endtask

    task automatic model_write(input logic [DW-1:0] wd, input bit wl);
`ifdef MFCC_FRAME_FIFO_LEN_CHECK_EN
        if (discard) begin
            if (wl) begin
                discard = 1'b0;
                exp_err = 1'b1;
            end
        end else begin
            pq.push_back(wd);
            if (pq.size() == FL) begin
                if (wl) model_commit();
                else begin
                    pq.delete();
                    discard = 1'b1;
                end
            end else if (wl) begin
                pq.delete();
                exp_err = 1'b1;
            end
        end
`else
        pq.push_back(wd);
        if (pq.size() == FL) model_commit();
`endif
    endtask

    // One clock: entered and left at a negedge, inputs held for the edge.
    task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit wl, input bit rr);
        bit wacc, racc;
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        rd_ready = rr;
        wacc = wv && m_wr_ready();
        racc = rr && m_rd_valid();
        @(posedge clk);
        exp_err = 1'b0;
        if (racc) void'(cq.pop_front());
        if (wacc) model_write(wd, wl);
        @(negedge clk);
    endtask

    task automatic write_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) drive(1'b1, base + DW'(i), (i == FL - 1), 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({frame_cnt, rd_valid, wr_ready, wr_err} !== {CW'(0), 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_state cnt/rv/wrdy/err got %0d/%b/%b/%b need 0/0/1/0",
                     frame_cnt, rd_valid, wr_ready, wr_err);
        else passed++;
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 2 * FL; i++) drive(1'b1, DW'(i), (i % FL == FL - 1), 1'b0);
        total++;
        if (frame_cnt !== CW'(2)) $display("FAIL fill_cnt got %0d need 2", frame_cnt);
        else passed++;
        for (int i = 0; i < 2 * FL; i++) begin
            total++;
            if ({rd_valid, rd_data, rd_first, rd_last} !== {1'b1, DW'(i), (i % FL == 0), (i % FL == FL - 1)})
                $display("FAIL drain_word%0d got v%b d%0d f%b l%b need v1 d%0d f%b l%b", i,
                         rd_valid, rd_data, rd_first, rd_last, i, (i % FL == 0), (i % FL == FL - 1));
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        total++;
        if ({frame_cnt, rd_valid} !== {CW'(0), 1'b0})
            $display("FAIL drain_empty cnt/rv got %0d/%b need 0/0", frame_cnt, rd_valid);
        else passed++;
    endtask

    task automatic test_full();
        for (int f = 0; f < NF; f++) write_frame(DW'($urandom));
        drive(1'b1, 32'hdead_beef, 1'b0, 1'b0);
        total++;
        if ({frame_cnt, wr_ready} !== {CW'(NF), 1'b0})
            $display("FAIL full_state cnt/wrdy got %0d/%b need %0d/0", frame_cnt, wr_ready, NF);
        else passed++;
        for (int i = 0; i < FL - 1; i++) drive(1'b0, '0, 1'b0, 1'b1);
        total++;
        if ({wr_ready, rd_last} !== 2'b01)
            $display("FAIL full_no_bypass wrdy/rlast got %b/%b need 0/1", wr_ready, rd_last);
        else passed++;
        drive(1'b0, '0, 1'b0, 1'b1);
        total++;
        if ({frame_cnt, wr_ready} !== {CW'(NF - 1), 1'b1})
            $display("FAIL full_release cnt/wrdy got %0d/%b need %0d/1", frame_cnt, wr_ready, NF - 1);
        else passed++;
        while (cq.size() != 0) begin
            total++;
            if (rd_data !== cq[0]) $display("FAIL full_drain data got %0h need %0h", rd_data, cq[0]);
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_simultaneous();
        write_frame(DW'(1000));
        for (int i = 0; i < FL - 1; i++) drive(1'b1, DW'(2000 + i), 1'b0, 1'b0);
        for (int i = 0; i < FL - 1; i++) drive(1'b0, '0, 1'b0, 1'b1);
        total++;
        if ({frame_cnt, rd_data, rd_last} !== {CW'(1), DW'(1000 + FL - 1), 1'b1})
            $display("FAIL simul_pre cnt/data/last got %0d/%0d/%b need 1/%0d/1",
                     frame_cnt, rd_data, rd_last, 1000 + FL - 1);
        else passed++;
        drive(1'b1, DW'(2000 + FL - 1), 1'b1, 1'b1);
        total++;
        if ({frame_cnt, rd_data, rd_first} !== {CW'(1), DW'(2000), 1'b1})
            $display("FAIL simul_post cnt/data/first got %0d/%0d/%b need 1/2000/1",
                     frame_cnt, rd_data, rd_first);
        else passed++;
        for (int i = 0; i < FL; i++) begin
            total++;
            if (rd_data !== DW'(2000 + i)) $display("FAIL simul_drain%0d got %0d need %0d", i, rd_data, 2000 + i);
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

`ifdef MFCC_FRAME_FIFO_LEN_CHECK_EN
    task automatic test_short();
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(50 + i), (i == 5), 1'b0);
        total++;
        if ({wr_err, frame_cnt} !== {1'b1, CW'(0)})
            $display("FAIL short_err err/cnt got %b/%0d need 1/0", wr_err, frame_cnt);
        else passed++;
        drive(1'b0, '0, 1'b0, 1'b0);
        total++;
        if (wr_err !== 1'b0) $display("FAIL short_pulse_len got %b need 0", wr_err);
        else passed++;
        write_frame(DW'(600));
        for (int i = 0; i < FL; i++) begin
            total++;
            if (rd_data !== DW'(600 + i)) $display("FAIL short_next%0d got %0d need %0d", i, rd_data, 600 + i);
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
    endtask
`endif

    task automatic test_long();
        int errs = 0;
        for (int i = 0; i < FL + 3; i++) begin
            drive(1'b1, DW'(700 + i), (i == FL + 2), 1'b0);
            if (wr_err === 1'b1) errs++;
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        if (wr_err === 1'b1) errs++;
`ifdef MFCC_FRAME_FIFO_LEN_CHECK_EN
        total++;
        if ({errs[3:0], frame_cnt, rd_valid} !== {4'd1, CW'(0), 1'b0})
            $display("FAIL long_drop errs/cnt/rv got %0d/%0d/%b need 1/0/0", errs, frame_cnt, rd_valid);
        else passed++;
        write_frame(DW'(300));
        for (int i = 0; i < FL; i++) begin
            total++;
            if (rd_data !== DW'(300 + i)) $display("FAIL long_next%0d got %0d need %0d", i, rd_data, 300 + i);
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
`else
        total++;
        if ({errs[3:0], frame_cnt} !== {4'd0, CW'(1)})
            $display("FAIL long_count errs/cnt got %0d/%0d need 0/1", errs, frame_cnt);
        else passed++;
        for (int i = 0; i < FL - 3; i++) drive(1'b1, DW'(800 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2 * FL; i++) begin
            logic [DW-1:0] need;
            need = (i < FL + 3) ? DW'(700 + i) : DW'(800 + i - FL - 3);
            total++;
            if (rd_data !== need) $display("FAIL long_read%0d got %0d need %0d", i, rd_data, need);
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        write_frame(DW'(900));
        for (int i = 0; i < 7; i++) drive(1'b1, DW'(950 + i), 1'b0, 1'b0);
        wr_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({frame_cnt, rd_valid, wr_ready, wr_err} !== {CW'(0), 1'b0, 1'b1, 1'b0})
            $display("FAIL rst_mid cnt/rv/wrdy/err got %0d/%b/%b/%b need 0/0/1/0",
                     frame_cnt, rd_valid, wr_ready, wr_err);
        else passed++;
        @(negedge clk);
        rstn = 1'b1;
        model_clear();
        write_frame(DW'(400));
        for (int i = 0; i < FL; i++) begin
            total++;
            if ({rd_data, rd_first} !== {DW'(400 + i), (i == 0)})
                $display("FAIL rst_fresh%0d got %0d/%b need %0d/%b", i, rd_data, rd_first, 400 + i, (i == 0));
            else passed++;
            drive(1'b0, '0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            bit wv, wl, rr;
            wv = ($urandom % 4) != 0;
            rr = ($urandom % 3) != 0;
            if (discard) wl = ($urandom % 3) == 0;
            else if (pq.size() == FL - 1) wl = ($urandom % 8) != 0;
            else wl = ($urandom % 30) == 0;
            total++;
            if ({rd_valid, rd_first, rd_last, wr_ready, wr_err, frame_cnt} !==
                {m_rd_valid(), m_first(), m_last(), m_wr_ready(), exp_err, CW'(m_cnt())})
                $display("FAIL rand_ctrl%0d v/f/l/wrdy/err/cnt got %b%b%b%b%b/%0d need %b%b%b%b%b/%0d", n,
                         rd_valid, rd_first, rd_last, wr_ready, wr_err, frame_cnt,
                         m_rd_valid(), m_first(), m_last(), m_wr_ready(), exp_err, m_cnt());
            else passed++;
            if (cq.size() != 0) begin
                total++;
                if (rd_data !== cq[0]) $display("FAIL rand_data%0d got %0h need %0h", n, rd_data, cq[0]);
                else passed++;
            end
            drive(wv, DW'($urandom), wl, rr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_full();
        test_simultaneous();
`ifdef MFCC_FRAME_FIFO_LEN_CHECK_EN
        test_short();
`endif
        test_long();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
